imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Immediate generator with a registered 2-entry skid buffer.
//               Each accepted instruction is decoded on the input side
//               (format, sign/zero-extended immediate, illegal flag).
//               The decoded result is then held in a valid/ready buffer that
//               sustains one instruction per cycle.
//               Optional macro IMM_GEN_FP_EN adds the FP load/store/arith
//               opcodes to the legal set and enables out_imm_fp.
// Ports       : clk, rst (async, active-high), flush (sync discard)
//               in_valid/in_ready/in_instr/in_sel  - upstream handshake
//               out_valid/out_ready                - downstream handshake
//               out_instr/out_imm_int/out_imm_fp/out_fmt/out_illegal - payload
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [1:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm_int,
    output logic [XLEN-1:0] out_imm_fp,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    // Format codes presented on out_fmt
    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;
    localparam logic [2:0] c_FMT_Z    = 3'd6;

    // Integer opcodes
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_REG32  = 7'b0111011;

`ifdef IMM_GEN_FP_EN
    localparam logic       c_FP_EN     = 1'b1;
    localparam logic [6:0] c_OP_FLW    = 7'b0000111;
    localparam logic [6:0] c_OP_FSW    = 7'b0100111;
    localparam logic [6:0] c_OP_FP     = 7'b1010011;
    localparam logic [6:0] c_OP_FMADD  = 7'b1000011;
    localparam logic [6:0] c_OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] c_OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] c_OP_FNMADD = 7'b1001111;
`else
    localparam logic       c_FP_EN     = 1'b0;
`endif

    // Buffer occupancy states
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    // Entry layout: {instr, imm_int, imm_fp, fmt, illegal}
    localparam int c_PW = 32 + 2 * XLEN + 3 + 1;

    logic [6:0]      w_opcode;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_imm_int;
    logic [XLEN-1:0] w_imm_fp;
    logic [c_PW-1:0] w_entry;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_skid;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_load_head_in;
    logic            w_load_head_skid;
    logic            w_load_skid;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_opcode = in_instr[6:0];

    always_comb begin : p_format
        w_fmt     = c_FMT_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_BRANCH: w_fmt = c_FMT_B;
            c_OP_JAL:    w_fmt = c_FMT_J;
            c_OP_JALR,
            c_OP_IMM,
            c_OP_LOAD:   w_fmt = c_FMT_I;
            c_OP_STORE:  w_fmt = c_FMT_S;
            c_OP_LUI,
            c_OP_AUIPC:  w_fmt = c_FMT_U;
            // CSR immediate forms carry funct3[2]=1 and use rs1 as zimm
            c_OP_SYSTEM: w_fmt = in_instr[14] ? c_FMT_Z : c_FMT_I;
            c_OP_IMM32: begin
                if (XLEN == 64) begin
                    w_fmt = c_FMT_I;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_REG:    w_illegal = 1'b0;
            c_OP_REG32:  w_illegal = (XLEN != 64);
`ifdef IMM_GEN_FP_EN
            c_OP_FLW:    w_fmt = c_FMT_I;
            c_OP_FSW:    w_fmt = c_FMT_S;
            c_OP_FP,
            c_OP_FMADD,
            c_OP_FMSUB,
            c_OP_FNMSUB,
            c_OP_FNMADD: w_illegal = 1'b0;
`endif
            default:     w_illegal = 1'b1;
        endcase
    end

    always_comb begin : p_imm
        w_imm32 = '0;
        case (w_fmt)
            c_FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            c_FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            c_FMT_U: w_imm32 = {in_instr[31:12], 12'h000};
            c_FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            c_FMT_Z: w_imm32 = {27'd0, in_instr[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    // Bit 31 of w_imm32 already holds the sign (0 for zimm), so widening to
    // XLEN is a plain replication of that bit.
    generate
        if (XLEN > 32) begin : g_sext_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_sext_narrow
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_imm_int = in_sel[0] ? w_imm : '0;
    assign w_imm_fp  = (c_FP_EN && in_sel[1]) ? w_imm : '0;
    assign w_entry   = {in_instr, w_imm_int, w_imm_fp, w_fmt, w_illegal};

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    assign in_ready   = (r_state != c_TWO) && !rst;
    assign out_valid  = (r_state != c_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // Flush wins over both handshakes; any same-cycle input is lost
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = c_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                c_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: w_load_head_in = 1'b1;
                        2'b10: begin
                            w_state_nxt = c_TWO;
                            w_load_skid = 1'b1;
                        end
                        2'b01: w_state_nxt = c_EMPTY;
                        default: w_state_nxt = c_ONE;
                    endcase
                end
                c_TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (w_out_fire) begin
                        w_state_nxt      = c_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_payload
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_entry;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    assign {out_instr, out_imm_int, out_imm_fp, out_fmt, out_illegal} = r_head;

endmodule
`default_nettype wire
